video_scanout: RTL and testbench

- Pixel-clock video stage that consumes the video-RAM read port of the arcade memory. It reads the 7K frame buffer at 14'h2400-14'h3FFF.
- Generates 640x480@60 timing from the 25 MHz clock.
- Fetches frame-buffer bytes through the one-cycle read handshake and serialises them to a 1-bit pixel, shown at 2x scale (512x448) centred in the active area.
- Also produces the mid-screen and vblank interrupt strobes for the CPU interrupt logic.

---
 rtl/video_scanout.sv | 101 ++++++++++
 tb/tb_video_scanout.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/video_scanout.sv
// 640x480@60 scanout of the 256x224 1bpp frame buffer at 2x scale, with mid-screen/vblank strobes.
// Latency: video outputs lag the internal counters by one cycle; no backpressure, and a fetch with no i_ready2 shows dark.
module video_scanout #(
  parameter logic [13:0] VRAM_BASE = 14'h2400,
  parameter int          H_OFS     = 64,
  parameter int          V_OFS     = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  output logic [13:0] o_addr2,
  output logic        o_read2,
  input  logic [7:0]  i_data2,
  input  logic        i_ready2,
  output logic        o_pixel,
  output logic        o_de,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic [9:0]  o_hcount,
  output logic [9:0]  o_vcount,
  output logic        o_irq_mid,
  output logic        o_irq_vbl,
  output logic        o_underrun
);

  localparam logic [9:0] H0    = 10'(H_OFS);
  localparam logic [9:0] FH0   = 10'(H_OFS - 4);
  localparam logic [9:0] V0    = 10'(V_OFS);
  localparam logic [9:0] MID_V = 10'(V_OFS + 192);
  localparam logic [9:0] VBL_V = 10'(V_OFS + 448);

  logic [9:0] h, v, nh, nv;
  logic [9:0] fh_ofs, fv_ofs, hw_ofs, vw_ofs;
  logic       fetch_nxt, in_win, load, shift_en, pix_src;
  logic [13:0] addr_nxt;
  logic       pend;
  logic [7:0] next_byte, shift_q;

  always_comb begin
    nh = (h == 10'd799) ? 10'd0 : h + 10'd1;
    nv = v;
    if (h == 10'd799) nv = (v == 10'd524) ? 10'd0 : v + 10'd1;
  end

  // Requests are decided from the next counter value so the registered strobe lines up with internal h.
  always_comb begin
    fh_ofs    = nh - FH0;
    fv_ofs    = nv - V0;
    fetch_nxt = (fv_ofs < 10'd448) && (fh_ofs < 10'd497) && (fh_ofs[3:0] == 4'd0);
    addr_nxt  = VRAM_BASE + {1'b0, fv_ofs[8:1], fh_ofs[8:4]};
  end

  // The first pixel of each byte bypasses the shift register, which is only loaded at the end of that cycle.
  always_comb begin
    hw_ofs   = h - H0;
    vw_ofs   = v - V0;
    in_win   = (hw_ofs < 10'd512) && (vw_ofs < 10'd448);
    load     = in_win && (hw_ofs[3:0] == 4'd0);
    shift_en = in_win && hw_ofs[0];
    pix_src  = load ? next_byte[0] : shift_q[0];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h          <= '0;
      v          <= '0;
      o_read2    <= 1'b0;
      o_addr2    <= VRAM_BASE;
      pend       <= 1'b0;
      next_byte  <= 8'h00;
      shift_q    <= 8'h00;
      o_underrun <= 1'b0;
      o_pixel    <= 1'b0;
      o_de       <= 1'b0;
      o_hsync    <= 1'b1;
      o_vsync    <= 1'b1;
      o_hcount   <= '0;
      o_vcount   <= '0;
      o_irq_mid  <= 1'b0;
      o_irq_vbl  <= 1'b0;
    end else begin
      h       <= nh;
      v       <= nv;
      o_read2 <= fetch_nxt;
      if (fetch_nxt) o_addr2 <= addr_nxt;
      pend       <= o_read2;
      o_underrun <= pend && !i_ready2;
      if (pend) next_byte <= i_ready2 ? i_data2 : 8'h00;
      if (load)          shift_q <= next_byte;
      else if (shift_en) shift_q <= {1'b0, shift_q[7:1]};
      o_pixel   <= in_win && pix_src;
      o_de      <= (h < 10'd640) && (v < 10'd480);
      o_hsync   <= !((h >= 10'd656) && (h < 10'd752));
      o_vsync   <= !((v == 10'd490) || (v == 10'd491));
      o_hcount  <= h;
      o_vcount  <= v;
      o_irq_mid <= (h == 10'd0) && (v == MID_V);
      o_irq_vbl <= (h == 10'd0) && (v == VBL_V);
    end
  end

endmodule

// File: tb/tb_video_scanout.sv
// Self-checking bench for video_scanout: memory-port responder plus a frame-geometry reference model.
module tb_video_scanout;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [13:0] o_addr2;
  logic        o_read2;
  logic [7:0]  i_data2;
  logic        i_ready2;
  logic        o_pixel, o_de, o_hsync, o_vsync;
  logic [9:0]  o_hcount, o_vcount;
  logic        o_irq_mid, o_irq_vbl, o_underrun;

  video_scanout dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_addr2(o_addr2), .o_read2(o_read2), .i_data2(i_data2), .i_ready2(i_ready2),
    .o_pixel(o_pixel), .o_de(o_de), .o_hsync(o_hsync), .o_vsync(o_vsync),
    .o_hcount(o_hcount), .o_vcount(o_vcount),
    .o_irq_mid(o_irq_mid), .o_irq_vbl(o_irq_vbl), .o_underrun(o_underrun)
  );

  always #20 i_clk = ~i_clk;

  localparam logic [13:0] DROP_ADDR = 14'h2945;  // row 42 (line 100), byte column 5

  logic [7:0]  mem [0:16383];
  logic        pend_req, pend_drop;
  logic [13:0] pend_addr;
  int n_chk, n_fail;
  int eh, ev;
  int err_pos, err_tim, err_pix, err_rd, err_irq;
  int n_de, n_hs, n_vs, n_rd, n_mid, n_vbl, n_und, und_v;
  int lit16, lit17, lit462, lit463, lit100, lit101, rd464;
  int first_rd_v, first_rd_h;
  logic [13:0] last_addr, first_addr;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_pix(input int hh, input int vv);
    int r, c;
    logic [7:0] b;
    if (hh < 64 || hh >= 576 || vv < 16 || vv >= 464) return 1'b0;
    r = (vv - 16) / 2;
    c = (hh - 64) / 16;
    b = mem[16'h2400 + r * 32 + c];
    if (vv == 100 && c == 5) b = 8'h00;
    return b[((hh - 64) / 2) % 8];
  endfunction

  // One clock: answer last cycle's request just after the edge, then sample on the falling edge.
  task automatic cyc();
    @(posedge i_clk);
    #1;
    if (pend_req && !pend_drop) begin
      i_ready2 = 1'b1;
      i_data2  = mem[pend_addr];
    end else begin
      i_ready2 = 1'b0;
      i_data2  = 8'($urandom);
    end
    @(negedge i_clk);
    pend_req  = o_read2;
    pend_addr = o_addr2;
    pend_drop = (o_vcount == 10'd100) && (o_addr2 == DROP_ADDR);
  endtask

  task automatic clr_stats();
    err_pos = 0; err_tim = 0; err_pix = 0; err_rd = 0; err_irq = 0;
    n_de = 0; n_hs = 0; n_vs = 0; n_rd = 0; n_mid = 0; n_vbl = 0; n_und = 0; und_v = -1;
    lit16 = 0; lit17 = 0; lit462 = 0; lit463 = 0; lit100 = 0; lit101 = 0; rd464 = 0;
    first_rd_v = -1; first_rd_h = -1; last_addr = '0; first_addr = '0;
  endtask

  task automatic advance();
    eh++;
    if (eh == 800) begin
      eh = 0;
      ev = (ev == 524) ? 0 : ev + 1;
    end
  endtask

  // Outputs at this sample describe screen position (eh,ev); the read strobe belongs to column eh+1.
  task automatic do_check();
    int ih;
    logic e_rd, e_de, e_hs, e_vs;
    logic [13:0] e_addr;
    ih     = eh + 1;
    e_rd   = (ev >= 16 && ev < 464 && ih >= 60 && ih <= 556 && (ih - 60) % 16 == 0);
    e_addr = 14'(16'h2400 + ((ev - 16) / 2) * 32 + (ih - 60) / 16);
    e_de   = (eh < 640 && ev < 480);
    e_hs   = !(eh >= 656 && eh < 752);
    e_vs   = !(ev == 490 || ev == 491);
    if (o_hcount !== 10'(eh) || o_vcount !== 10'(ev)) err_pos++;
    if (o_de !== e_de || o_hsync !== e_hs || o_vsync !== e_vs) err_tim++;
    if (o_read2 !== e_rd || (e_rd && o_addr2 !== e_addr)) err_rd++;
    if (o_pixel !== exp_pix(eh, ev)) err_pix++;
    if (o_irq_mid !== (eh == 0 && ev == 208) || o_irq_vbl !== (eh == 0 && ev == 464)) err_irq++;
    if (o_de === 1'b1) n_de++;
    if (o_hsync === 1'b0) n_hs++;
    if (o_vsync === 1'b0) n_vs++;
    if (o_irq_mid === 1'b1) n_mid++;
    if (o_irq_vbl === 1'b1) n_vbl++;
    if (o_underrun === 1'b1) begin n_und++; und_v = ev; end
    if (o_read2 === 1'b1) begin
      n_rd++;
      last_addr = o_addr2;
      if (ev == 464) rd464++;
      if (first_rd_v < 0) begin first_rd_v = ev; first_rd_h = ih; first_addr = o_addr2; end
    end
    if (o_pixel === 1'b1) begin
      if (ev == 16) lit16++;
      if (ev == 17) lit17++;
      if (ev == 462 && eh >= 560 && eh < 576) lit462++;
      if (ev == 463 && eh >= 560 && eh < 576) lit463++;
      if (ev == 100 && eh >= 144 && eh < 160) lit100++;
      if (ev == 101 && eh >= 144 && eh < 160) lit101++;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_read2"},   32'(o_read2),   32'd0);
    chk({tag, "_addr2"},   32'(o_addr2),   32'h2400);
    chk({tag, "_pixel"},   32'(o_pixel),   32'd0);
    chk({tag, "_de"},      32'(o_de),      32'd0);
    chk({tag, "_hsync"},   32'(o_hsync),   32'd1);
    chk({tag, "_vsync"},   32'(o_vsync),   32'd1);
    chk({tag, "_hcount"},  32'(o_hcount),  32'd0);
    chk({tag, "_vcount"},  32'(o_vcount),  32'd0);
    chk({tag, "_strobes"}, {29'd0, o_irq_mid, o_irq_vbl, o_underrun}, 32'd0);
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    pend_req = 1'b0; pend_drop = 1'b0; pend_addr = '0;
    for (int a = 0; a < 16384; a++) mem[a] = 8'($urandom);
    for (int a = 16'h2400; a < 16'h2420; a++) mem[a] = 8'h00;
    mem[14'h2400] = 8'h01;
    mem[14'h2401] = 8'h80;
    mem[14'h3FFF] = 8'hFF;

    i_rst = 1'b1; i_ready2 = 1'b0; i_data2 = 8'h00;
    repeat (3) cyc();
    chk_reset("rst");

    // Full first frame.
    i_rst = 1'b0;
    eh = 0; ev = 0;
    clr_stats();
    for (int k = 0; k < 800 * 525; k++) begin
      cyc();
      do_check();
      advance();
    end
    chk("f1_position_err", 32'(err_pos), 32'd0);
    chk("f1_timing_err",   32'(err_tim), 32'd0);
    chk("f1_pixel_err",    32'(err_pix), 32'd0);
    chk("f1_read_err",     32'(err_rd),  32'd0);
    chk("f1_irq_err",      32'(err_irq), 32'd0);
    chk("f1_de_cycles",    32'(n_de),    32'd307200);
    chk("f1_hsync_low",    32'(n_hs),    32'd50400);
    chk("f1_vsync_low",    32'(n_vs),    32'd1600);
    chk("f1_reads",        32'(n_rd),    32'd14336);
    chk("f1_irq_mid_cnt",  32'(n_mid),   32'd1);
    chk("f1_irq_vbl_cnt",  32'(n_vbl),   32'd1);
    chk("f1_underrun_cnt", 32'(n_und),   32'd1);
    chk("f1_underrun_line", 32'(und_v),  32'd100);
    chk("f1_lit_line16",   32'(lit16),   32'd4);
    chk("f1_lit_line17",   32'(lit17),   32'd4);
    chk("f1_lit_line462",  32'(lit462),  32'd16);
    chk("f1_lit_line463",  32'(lit463),  32'd16);
    chk("f1_dark_line100", 32'(lit100),  32'd0);
    chk("f1_lit_line101",  32'(lit101),  32'(2 * $countones(mem[DROP_ADDR])));
    chk("f1_last_addr",    32'(last_addr), 32'h3FFF);
    chk("f1_reads_line464", 32'(rd464),  32'd0);
    chk("f1_first_read_h", 32'(first_rd_h), 32'd60);
    chk("f1_first_read_v", 32'(first_rd_v), 32'd16);
    chk("f1_first_addr",   32'(first_addr), 32'h2400);

    // Into the second frame, then a one-cycle reset mid-line.
    clr_stats();
    for (int k = 0; k < 20000; k++) begin
      cyc();
      do_check();
      if (eh == 399 && ev == 20) break;
      advance();
    end
    chk("f2_reached_reset_point", 32'(eh * 1000 + ev), 32'd399020);
    chk("f2_pixel_err", 32'(err_pix), 32'd0);
    chk("f2_read_err",  32'(err_rd),  32'd0);
    i_rst = 1'b1;
    cyc();
    chk_reset("midrst");
    i_rst = 1'b0;

    eh = 0; ev = 0;
    clr_stats();
    for (int k = 0; k < 18 * 800; k++) begin
      cyc();
      do_check();
      advance();
    end
    chk("rr_position_err", 32'(err_pos), 32'd0);
    chk("rr_timing_err",   32'(err_tim), 32'd0);
    chk("rr_pixel_err",    32'(err_pix), 32'd0);
    chk("rr_read_err",     32'(err_rd),  32'd0);
    chk("rr_irq_pulses",   32'(n_mid + n_vbl), 32'd0);
    chk("rr_first_read_v", 32'(first_rd_v), 32'd16);
    chk("rr_first_read_h", 32'(first_rd_h), 32'd60);
    chk("rr_first_addr",   32'(first_addr), 32'h2400);
    chk("rr_reads",        32'(n_rd), 32'd64);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
